// File: rtl/stroke_sequencer.sv
// stroke_sequencer
//
// Tracks crank angle across a four-stroke engine cycle and derives the
// per-cylinder stroke, the injection/ignition windows and the controller
// enables. The crank reference (ckp) must line up with the angle wrap;
// otherwise sync is dropped and re-acquired.
//
// Ports:
//   clk             - single clock
//   reset_n         - asynchronous active-low reset
//   crank_tick      - one-clk crank tooth strobe
//   crank_changed   - qualifies crank_tick (crank counter really moved)
//   on              - sequencer enable
//   ckp             - cycle reference level, rising edge = angle 0
//   stroke          - per-cylinder stroke (0 intake .. 3 exhaust)
//   allow_injection - per-cylinder injection window active
//   allow_ignition  - per-cylinder ignition window active
//   fic_on / ic_on  - per-cylinder controller enables
//   synced          - sequencer locked to the crank
//   sync_err        - one-clk pulse on loss of sync
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | disabled, all outputs 0
// WAIT_SYNC | enabled, waiting for a ckp rising edge to set angle 0
// RUN       | locked, angle follows qualified crank ticks

module stroke_sequencer #(
    parameter int CYLINDERS        = 4,
    parameter int TICKS_PER_STROKE = 180,
    parameter logic [16*CYLINDERS-1:0] PHASE_OFS = {16'(2*TICKS_PER_STROKE),
                                                    16'(TICKS_PER_STROKE),
                                                    16'(3*TICKS_PER_STROKE),
                                                    16'd0},
    parameter int INJ_START        = 0,
    parameter int INJ_END          = 180,
    parameter int IGN_START        = 330,
    parameter int IGN_END          = 360,
    parameter int STALL_CLKS       = 1000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       crank_tick,
    input  logic                       crank_changed,
    input  logic                       on,
    input  logic                       ckp,
    output logic [CYLINDERS-1:0][1:0]  stroke,
    output logic [CYLINDERS-1:0]       allow_injection,
    output logic [CYLINDERS-1:0]       allow_ignition,
    output logic [CYLINDERS-1:0]       fic_on,
    output logic [CYLINDERS-1:0]       ic_on,
    output logic                       synced,
    output logic                       sync_err
);

    localparam int CYCLE = 4 * TICKS_PER_STROKE;
    localparam int AW    = $clog2(CYCLE);
    localparam int SW    = $clog2(STALL_CLKS + 1);

    localparam logic [AW-1:0] ANGLE_LAST = AW'(CYCLE - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CLKS - 1);
    localparam logic [16:0]   CYCLE17    = 17'(CYCLE);
    localparam logic [16:0]   TPS17      = 17'(TICKS_PER_STROKE);
    localparam logic [16:0]   INJ_S17    = 17'(INJ_START);
    localparam logic [16:0]   INJ_LEN17  = 17'(INJ_END - INJ_START);
    localparam logic [16:0]   IGN_S17    = 17'(IGN_START);
    localparam logic [16:0]   IGN_LEN17  = 17'(IGN_END - IGN_START);

    generate
        if (CYLINDERS < 1 || CYLINDERS > 8) begin : g_bad_cyl
            $error("stroke_sequencer: CYLINDERS must be 1..8");
        end
        if (INJ_START > INJ_END || IGN_START > IGN_END) begin : g_bad_win
            $error("stroke_sequencer: window start exceeds window end");
        end
        for (genvar c = 0; c < CYLINDERS; c++) begin : g_ofs_chk
            if (int'(PHASE_OFS[16*c +: 16]) >= CYCLE) begin : g_bad_ofs
                $error("stroke_sequencer: phase offset not below cycle length");
            end
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   angle, angle_nx;
    logic [SW-1:0]   stall, stall_nx;
    logic            ckp_q;
    logic            err_nx;

    logic qtick, ckp_rise, wrap;
    assign qtick    = crank_tick & crank_changed;
    assign ckp_rise = ckp & ~ckp_q;
    assign wrap     = qtick && (angle == ANGLE_LAST);

    always_comb begin
        state_nx = state;
        angle_nx = angle;
        stall_nx = stall;
        err_nx   = 1'b0;
        if (!on) begin
            state_nx = IDLE;
            angle_nx = '0;
            stall_nx = '0;
        end else begin
            case (state)
                IDLE: state_nx = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (ckp_rise) begin
                        state_nx = RUN;
                        angle_nx = '0;
                        stall_nx = '0;
                    end
                end
                RUN: begin
                    // Sync is good only when the reference edge and the
                    // wrap coincide; either one alone is a sync loss.
                    if (ckp_rise != wrap) begin
                        err_nx   = 1'b1;
                        state_nx = WAIT_SYNC;
                        angle_nx = '0;
                        stall_nx = '0;
                    end else if (qtick) begin
                        angle_nx = wrap ? '0 : angle + 1'b1;
                        stall_nx = '0;
                    end else if (stall == STALL_LAST) begin
                        state_nx = WAIT_SYNC;
                        angle_nx = '0;
                        stall_nx = '0;
                    end else begin
                        stall_nx = stall + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next angle so they move on the same
    // edge as the angle register.
    logic [16:0]                phase [CYLINDERS];
    logic [CYLINDERS-1:0][1:0]  stroke_w;
    logic [CYLINDERS-1:0]       inj_w, ign_w;

    generate
        for (genvar g = 0; g < CYLINDERS; g++) begin : g_cyl
            logic [16:0] sum;
            assign sum = {{(17-AW){1'b0}}, angle_nx} + {1'b0, PHASE_OFS[16*g +: 16]};
            // Both terms are below CYCLE, so one subtraction is the modulo.
            assign phase[g]    = (sum >= CYCLE17) ? sum - CYCLE17 : sum;
            assign stroke_w[g] = 2'(phase[g] / TPS17);
            // Unsigned offset trick: below start wraps to a large value.
            assign inj_w[g]    = (phase[g] - INJ_S17) < INJ_LEN17;
            assign ign_w[g]    = (phase[g] - IGN_S17) < IGN_LEN17;
        end
    endgenerate

    logic run_nx;
    assign run_nx = (state_nx == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            angle           <= '0;
            stall           <= '0;
            ckp_q           <= 1'b0;
            stroke          <= '0;
            allow_injection <= '0;
            allow_ignition  <= '0;
            fic_on          <= '0;
            ic_on           <= '0;
            synced          <= 1'b0;
            sync_err        <= 1'b0;
        end else begin
            state           <= state_nx;
            angle           <= angle_nx;
            stall           <= stall_nx;
            ckp_q           <= ckp;
            stroke          <= run_nx ? stroke_w : '0;
            allow_injection <= run_nx ? inj_w : '0;
            allow_ignition  <= run_nx ? ign_w : '0;
            fic_on          <= {CYLINDERS{run_nx}};
            ic_on           <= {CYLINDERS{run_nx}};
            synced          <= run_nx;
            sync_err        <= err_nx;
        end
    end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Testbench for stroke_sequencer: directed lock/advance/sync-loss/stall/
// priority/reset steps plus a randomized stretch, all checked against a
// behavioural cycle model of the crank sequencer.

module tb_stroke_sequencer;

    localparam int CYL   = 4;
    localparam int TPS   = 4;
    localparam int CYC   = 16;
    localparam int STALL = 20;
    localparam logic [63:0] OFS = {16'd8, 16'd4, 16'd12, 16'd0};

    int ofs_tab [CYL] = '{0, 12, 4, 8};

    logic           clk = 1'b0;
    logic           reset_n;
    logic           crank_tick, crank_changed, on, ckp;
    logic [3:0][1:0] stroke;
    logic [3:0]     allow_injection, allow_ignition, fic_on, ic_on;
    logic           synced, sync_err;

    stroke_sequencer #(
        .CYLINDERS(CYL), .TICKS_PER_STROKE(TPS), .PHASE_OFS(OFS),
        .INJ_START(0), .INJ_END(4), .IGN_START(6), .IGN_END(8),
        .STALL_CLKS(STALL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .crank_tick(crank_tick),
        .crank_changed(crank_changed), .on(on), .ckp(ckp),
        .stroke(stroke), .allow_injection(allow_injection),
        .allow_ignition(allow_ignition), .fic_on(fic_on), .ic_on(ic_on),
        .synced(synced), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = disabled, 1 = hunting for reference, 2 = locked.
    int m_mode, m_ang, m_idle_clks;
    bit m_prev_ckp, m_err;

    task automatic model_reset();
        m_mode = 0; m_ang = 0; m_idle_clks = 0; m_prev_ckp = 0; m_err = 0;
    endtask

    task automatic model_step(input bit o, input bit qt, input bit ck);
        bit rise;
        rise = ck && !m_prev_ckp;
        m_prev_ckp = ck;
        m_err = 0;
        if (!o) begin
            m_mode = 0; m_ang = 0; m_idle_clks = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rise) begin m_mode = 2; m_ang = 0; m_idle_clks = 0; end
        end else begin
            if (qt && m_ang == CYC - 1 && rise) begin
                m_ang = 0; m_idle_clks = 0;
            end else if (rise || (qt && m_ang == CYC - 1)) begin
                m_err = 1; m_mode = 1; m_ang = 0; m_idle_clks = 0;
            end else if (qt) begin
                m_ang = (m_ang + 1) % CYC; m_idle_clks = 0;
            end else begin
                m_idle_clks++;
                if (m_idle_clks == STALL) begin
                    m_mode = 1; m_ang = 0; m_idle_clks = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_stroke;
        logic [3:0] e_inj, e_ign, e_en;
        int ph;
        e_stroke = '0; e_inj = '0; e_ign = '0; e_en = '0;
        if (m_mode == 2) begin
            for (int i = 0; i < CYL; i++) begin
                ph = (m_ang + ofs_tab[i]) % CYC;
                e_stroke[2*i +: 2] = 2'(ph / TPS);
                e_inj[i] = (ph >= 0 && ph < 4);
                e_ign[i] = (ph >= 6 && ph < 8);
                e_en[i]  = 1'b1;
            end
        end
        chk({tag, ".stroke"}, 32'(stroke), 32'(e_stroke));
        chk({tag, ".inj"},    32'(allow_injection), 32'(e_inj));
        chk({tag, ".ign"},    32'(allow_ignition), 32'(e_ign));
        chk({tag, ".fic"},    32'(fic_on), 32'(e_en));
        chk({tag, ".ic"},     32'(ic_on), 32'(e_en));
        chk({tag, ".synced"}, 32'(synced), 32'(m_mode == 2));
        chk({tag, ".err"},    32'(sync_err), 32'(m_err));
    endtask

    // Inputs applied just after an edge, sampled at the next edge, checked 1 after.
    task automatic step(input bit o, input bit ct, input bit cc, input bit ck, input string tag);
        on = o; crank_tick = ct; crank_changed = cc; ckp = ck;
        @(posedge clk);
        model_step(o, ct && cc, ck);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ct, cc, ck, o;
        reset_n = 1'b0; on = 0; crank_tick = 0; crank_changed = 0; ckp = 0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Lock
        step(1, 0, 0, 0, "idle2wait");
        step(1, 0, 0, 1, "lock");
        chk("lock.stroke_d", 32'(stroke), 32'h9C);
        chk("lock.inj_d",    32'(allow_injection), 32'h1);
        chk("lock.fic_d",    32'(fic_on), 32'hF);
        chk("lock.synced_d", 32'(synced), 32'h1);

        // Advance
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, "adv");
        chk("adv6.stroke0", 32'(stroke[0]), 32'd1);
        chk("adv6.ign0",    32'(allow_ignition[0]), 32'd1);
        for (int i = 0; i < 2; i++) step(1, 1, 1, 0, "adv");
        chk("adv8.stroke0", 32'(stroke[0]), 32'd2);
        chk("adv8.ign0",    32'(allow_ignition[0]), 32'd0);

        // Unqualified ticks do not move the angle
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, "qual");
        chk("qual.stroke_d", 32'(stroke), 32'h36);

        // Good wrap
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, "to15");
        step(1, 1, 1, 1, "wrap");
        chk("wrap.synced_d", 32'(synced), 32'h1);
        chk("wrap.err_d",    32'(sync_err), 32'h0);
        chk("wrap.stroke_d", 32'(stroke), 32'h9C);

        // Bad sync at angle 5
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, "to5");
        step(1, 0, 0, 1, "badsync");
        chk("bad.err_d",    32'(sync_err), 32'h1);
        chk("bad.synced_d", 32'(synced), 32'h0);
        chk("bad.fic_d",    32'(fic_on), 32'h0);
        step(1, 0, 0, 0, "badsync1");
        chk("bad.err_pulse", 32'(sync_err), 32'h0);

        // Stall
        step(1, 0, 0, 1, "relock");
        for (int i = 0; i < STALL - 1; i++) step(1, 0, 0, 0, "stall");
        chk("stall19.synced", 32'(synced), 32'h1);
        step(1, 0, 0, 0, "stall20");
        chk("stall20.synced", 32'(synced), 32'h0);
        chk("stall20.err",    32'(sync_err), 32'h0);

        // Randomized stretch
        for (int n = 0; n < 400; n++) begin
            ct = 1'($urandom_range(0, 1));
            cc = ($urandom_range(0, 3) != 0);
            if (m_mode == 2 && m_ang == CYC - 1 && ct && cc && !m_prev_ckp)
                ck = ($urandom_range(0, 7) != 0);
            else
                ck = ($urandom_range(0, 29) == 0);
            o = ($urandom_range(0, 99) != 0);
            step(o, ct, cc, ck, "rand");
        end

        // on=0 beats a simultaneous good wrap
        step(0, 0, 0, 0, "prio_off");
        step(1, 0, 0, 0, "prio_wait");
        step(1, 0, 0, 1, "prio_lock");
        for (int i = 0; i < 15; i++) step(1, 1, 1, 0, "prio_adv");
        step(0, 1, 1, 1, "prio");
        chk("prio.synced", 32'(synced), 32'h0);
        chk("prio.stroke", 32'(stroke), 32'h0);
        chk("prio.err",    32'(sync_err), 32'h0);

        // Asynchronous reset mid-run
        step(1, 0, 0, 0, "ar_wait");
        step(1, 0, 0, 1, "ar_lock");
        step(1, 1, 1, 0, "ar_adv");
        step(1, 1, 1, 0, "ar_adv");
        ckp = 0;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst.synced", 32'(synced), 32'h0);
        chk("arst.fic",    32'(fic_on), 32'h0);
        check_all("arst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1, 1, 1, 0, "post_rst");
        chk("post_rst.synced", 32'(synced), 32'h0);
        step(1, 0, 0, 1, "post_rst_lock");
        step(1, 1, 1, 0, "post_rst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
